// File: rtl/heapsort_pkg.sv
// Shared types and helpers for the streaming heap sorter.
// Samples are compared at HS_MAX_W bits, so WIDTH must not exceed HS_MAX_W.
package heapsort_pkg;

  localparam int unsigned HS_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_BUILD,
    ST_SORT,
    ST_OUT
  } hs_state_e;

  // Micro-steps of one sift-down / root swap while in BUILD or SORT
  typedef enum logic [2:0] {
    PH_RDP,
    PH_RDC,
    PH_CMP,
    PH_SWR,
    PH_SWW
  } hs_phase_e;

  function automatic int unsigned heap_n(input int unsigned level);
    return (1 << level) - 1;
  endfunction

  // True when a must sit above b: max-heap for ascending, min-heap for descending
  function automatic logic hs_better(input logic [HS_MAX_W-1:0] a,
                                     input logic [HS_MAX_W-1:0] b,
                                     input logic                is_signed,
                                     input logic                descend);
    logic gt;
    logic lt;
    if (is_signed) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return descend ? lt : gt;
  endfunction

endpackage

// File: rtl/heapsort_stream_dp_ram.sv
// Two-port RAM, synchronous 1-cycle read on both ports, write-first per port.
module dp_ram #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  wdata_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  wdata_b,
  output logic [WIDTH-1:0]  rdata_b
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_a) begin
      mem[addr_a] <= wdata_a;
      rdata_a     <= wdata_a;
    end else begin
      rdata_a     <= mem[addr_a];
    end
    if (we_b) begin
      mem[addr_b] <= wdata_b;
      rdata_b     <= wdata_b;
    end else begin
      rdata_b     <= mem[addr_b];
    end
  end

endmodule

// File: rtl/heapsort_stream.sv
// Streaming heap sorter: loads N = 2^LEVEL-1 samples on fs edges, heap-sorts
// them in a dual-port RAM and bursts the sorted block out with a valid flag.
module heapsort_stream
  import heapsort_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LEVEL  = 2,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fs,
  input  logic             en_rec_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             descend,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             done,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned N  = heap_n(LEVEL);
  localparam int unsigned AW = LEVEL;
  localparam int unsigned XW = LEVEL + 1;
  localparam logic [AW-1:0] LAST  = AW'(N - 1);
  localparam logic [AW-1:0] NA    = AW'(N);
  localparam logic [AW-1:0] NODE0 = (N >= 3) ? AW'(N / 2 - 1) : '0;

  hs_state_e        state;
  hs_phase_e        ph;
  logic             fs_q;
  logic             desc_q;
  logic             p_fresh;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    node;
  logic [AW-1:0]    idx;
  logic [AW-1:0]    hsz;
  logic [WIDTH-1:0] pval;

  logic             we_a, we_b;
  logic [AW-1:0]    addr_a, addr_b;
  logic [WIDTH-1:0] wdata_a, wdata_b, rdata_a, rdata_b;

  logic             fs_edge;
  logic [XW-1:0]    lc, rc;
  logic             has_l, has_r;
  logic             r_better, do_swap, sift_end;
  logic [WIDTH-1:0] cval;
  logic [AW-1:0]    csel;

  function automatic logic [HS_MAX_W-1:0] ext(input logic [WIDTH-1:0] x);
    if (SIGNED) return HS_MAX_W'($signed(x));
    return HS_MAX_W'(x);
  endfunction

  assign fs_edge = fs & ~fs_q;
  assign lc      = {idx, 1'b1};
  assign rc      = lc + XW'(1);
  assign has_l   = lc < {1'b0, hsz};
  assign has_r   = rc < {1'b0, hsz};

  // Parent value lives in pval for the whole sift, so only the children are read
  always_comb begin
    r_better = has_r && hs_better(ext(rdata_b), ext(rdata_a), SIGNED, desc_q);
    cval     = r_better ? rdata_b : rdata_a;
    csel     = r_better ? rc[AW-1:0] : lc[AW-1:0];
    do_swap  = hs_better(ext(cval), ext(pval), SIGNED, desc_q);
    sift_end = ((state == ST_BUILD) || (state == ST_SORT)) &&
               (((ph == PH_RDC) && !has_l) || ((ph == PH_CMP) && !do_swap));
  end

  always_comb begin
    we_a    = 1'b0;
    we_b    = 1'b0;
    addr_a  = idx;
    addr_b  = '0;
    wdata_a = data_in;
    wdata_b = pval;
    unique case (state)
      ST_LOAD: begin
        addr_a = cnt;
        we_a   = fs_edge & en_rec_in;
      end
      ST_BUILD, ST_SORT: begin
        case (ph)
          PH_RDP: addr_a = idx;
          PH_RDC: begin
            addr_a = lc[AW-1:0];
            addr_b = rc[AW-1:0];
          end
          PH_CMP: begin
            if (do_swap) begin
              we_a    = 1'b1;
              addr_a  = idx;
              wdata_a = cval;
              we_b    = 1'b1;
              addr_b  = csel;
              wdata_b = pval;
            end
          end
          PH_SWR: begin
            addr_a = '0;
            addr_b = hsz - AW'(1);
          end
          PH_SWW: begin
            we_a    = 1'b1;
            addr_a  = '0;
            wdata_a = rdata_b;
            we_b    = 1'b1;
            addr_b  = hsz - AW'(1);
            wdata_b = rdata_a;
          end
          default: ;
        endcase
      end
      // Read one ahead: entry into OUT has already issued the read of address 0
      ST_OUT: addr_a = cnt + AW'(1);
      default: ;
    endcase
  end

  dp_ram #(
    .WIDTH (WIDTH),
    .ADDR_W(AW)
  ) u_ram (
    .clk    (clk),
    .we_a   (we_a),
    .addr_a (addr_a),
    .wdata_a(wdata_a),
    .rdata_a(rdata_a),
    .we_b   (we_b),
    .addr_b (addr_b),
    .wdata_b(wdata_b),
    .rdata_b(rdata_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      ph        <= PH_RDP;
      fs_q      <= 1'b0;
      desc_q    <= 1'b0;
      p_fresh   <= 1'b0;
      cnt       <= '0;
      node      <= '0;
      idx       <= '0;
      hsz       <= '0;
      pval      <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      fs_q      <= fs;
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (fs_edge && en_rec_in && (state != ST_LOAD)) overrun <= 1'b1;

      unique case (state)
        ST_LOAD: begin
          busy <= 1'b0;
          if (fs_edge && en_rec_in) begin
            if (cnt == LAST) begin
              cnt    <= '0;
              desc_q <= descend;
              busy   <= 1'b1;
              if (N == 1) begin
                state <= ST_OUT;
              end else begin
                state <= ST_BUILD;
                ph    <= PH_RDP;
                node  <= NODE0;
                idx   <= NODE0;
                hsz   <= NA;
              end
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end

        ST_BUILD, ST_SORT: begin
          case (ph)
            PH_RDP: begin
              p_fresh <= 1'b1;
              ph      <= PH_RDC;
            end
            PH_RDC: begin
              if (p_fresh) pval <= rdata_a;
              p_fresh <= 1'b0;
              if (has_l) ph <= PH_CMP;
            end
            PH_CMP: begin
              if (do_swap) begin
                idx <= csel;
                ph  <= PH_RDC;
              end
            end
            PH_SWR: begin
              if (hsz == AW'(1)) begin
                state <= ST_OUT;
                cnt   <= '0;
              end else begin
                ph <= PH_SWW;
              end
            end
            PH_SWW: begin
              pval    <= rdata_b;
              hsz     <= hsz - AW'(1);
              idx     <= '0;
              p_fresh <= 1'b0;
              ph      <= PH_RDC;
            end
            default: ph <= PH_RDP;
          endcase

          if (sift_end) begin
            if (state == ST_BUILD && node != '0) begin
              node <= node - AW'(1);
              idx  <= node - AW'(1);
              ph   <= PH_RDP;
            end else begin
              state <= ST_SORT;
              ph    <= PH_SWR;
            end
          end
        end

        ST_OUT: begin
          data_out  <= rdata_a;
          out_valid <= 1'b1;
          if (cnt == LAST) begin
            done  <= 1'b1;
            cnt   <= '0;
            state <= ST_LOAD;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end

        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: doc/heapsort_stream.md
# heapsort_stream

Parametrised streaming heap sorter. Collects a block of N = 2^LEVEL − 1 samples arriving on the `fs` sample strobe and sorts them in place with a binary heap. Sort direction and signedness are selectable. Emits the sorted block as a burst with a valid flag. This is the next generation of the fixed 32-bit, ascending-only `heapsort`. It sits between the sample source (file/ADC stream) and downstream statistics/median logic.

## Interface
- `WIDTH`, 32, sample width in bits (≥2)
- `LEVEL`, 2, heap levels; block size N = 2^LEVEL − 1 (LEVEL ≥ 1)
- `SIGNED`, 0, 1 = two's-complement compare, 0 = unsigned compare
- `clk` in 1: system clock; single clock domain
- `rst` in 1: synchronous, active-high reset
- `fs` in 1: sample strobe, synchronous to `clk`; a sample is taken on its rising edge
- `en_rec_in` in 1: receive enable; samples are accepted only while high
- `data_in` in WIDTH: sample, valid in the cycle the `fs` rising edge is detected
- `descend` in 1: 0 = ascending output, 1 = descending; latched at block start of sort
- `data_out` out WIDTH: sorted sample
- `out_valid` out 1: `data_out` valid this cycle
- `done` out 1: one-cycle pulse with the last sorted sample
- `busy` out 1: high while building, sorting or outputting
- `overrun` out 1: sticky; a sample edge arrived while not loading

## Operation
- Rise detect: `fs_q` is `fs` registered. An edge is `fs & ~fs_q`.
- FSM states: LOAD → BUILD → SORT → OUT → LOAD.
- LOAD:
  - On edge & `en_rec_in`: write `data_in` to mem[cnt] and increment cnt.
  - After the N-th write, latch `descend` and go to BUILD, with cnt cleared.
  - If N = 1, go directly to OUT.
- BUILD: sift-down nodes i = N/2−1 … 0 (0-based; children 2i+1, 2i+2).
  - Heap type is max-heap when `descend`=0 and min-heap when `descend`=1.
  - The comparison uses `SIGNED`.
- SORT: for size = N … 2:
  - Swap mem[0] with mem[size−1].
  - Sift-down root within size−1.
  - When size reaches 1, go to OUT.
- OUT:
  - Read mem[0 … N−1] in index order, one per cycle.
  - `out_valid`=1 for exactly N consecutive cycles.
  - `done` pulses with element N−1.
  - Then go to LOAD.
- Ties: equal values may be permuted. The multiset of output values must equal the multiset of input values.
- Edge with `en_rec_in`=1 in BUILD/SORT/OUT: sample dropped, `overrun` ← 1.
- Edge with `en_rec_in`=0 in any state: ignored, no flag.
- `overrun` is cleared only by `rst`.
- `descend` changes after the latch have no effect on the current block.

## Timing
- Reset values:
  - state LOAD, cnt 0, `fs_q` 0.
  - Outputs: `data_out` 0, `out_valid` 0, `done` 0, `busy` 0, `overrun` 0.
- Reset mid-block abandons the current data. Stale memory is never output, because the next block overwrites all N entries before OUT.
- Write occurs in the edge cycle. `busy` rises the cycle after the N-th write.
- BUILD + SORT take at most 4·N·LEVEL cycles.
- The first `out_valid` follows SORT completion by at most 2 cycles (RAM read latency 1).
- `busy` falls the cycle after `done`.
- LOAD accepts an edge in the cycle immediately after `busy` falls.
- `data_out` holds its last value when `out_valid`=0.

## Structure
- Package `heapsort_pkg` contains:
  - state enum;
  - `heap_n(LEVEL)` function;
  - compare function `hs_better(a, b, signed, descend)`.
- Sub-module `dp_ram`:
  - parameters WIDTH and ADDR_W = LEVEL;
  - two read/write ports with synchronous 1-cycle read.
  - Sift-down reads both children in one cycle. A swap writes parent and child in one cycle.
- Top level holds the FSM, counters, edge detect and flags.

## Test plan
- LEVEL=2, ascending, inputs 5, 1, 3 → `out_valid` ×3 yields 1, 3, 5; `done` on 5; `overrun`=0.
- Same inputs with `descend`=1 → 5, 3, 1.
- LEVEL=3, SIGNED=1, inputs FFFFFFFF, 2, 0, 7, 2, 80000000, 1 → 80000000, FFFFFFFF, 0, 1, 2, 2, 7. Check sort latency ≤ 84 cycles.
- LEVEL=1, input A5 → single `out_valid` with A5 and `done` in the same cycle.
- `fs` edges continue during SORT → `overrun`=1. Dropped values do not appear in the next block. The next block of 3 (9, 8, 7) yields 7, 8, 9.
- `rst` pulsed mid-SORT:
  - All outputs return to 0 the next cycle.
  - No `out_valid` occurs for the old block.
  - A fresh block 4, 4, 2 yields 2, 4, 4.
- `en_rec_in`=0 during edges → no writes. `busy` stays 0.
